pe_job_scheduler: RTL

- Sequences the convolution PE (`design_top`) through a queue of job descriptors.
- Each job carries filt_len, stride_len, calc_mod, the just_add (accumulate-input-psum) flag and an expected output count.
- Per job, the scheduler holds the configuration stable, pulses start, drains the PE output buffer into a valid/ready result stream (last-tagged), then retires the job.
- Sits between the host/command logic and the PE; data loading into the IF/filter/psum buffers stays external.

---
 rtl/pe_job_scheduler.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_job_scheduler.sv
// Job sequencer for the convolution PE: queues descriptors, launches each job,
// drains the PE output buffer into a last-tagged valid/ready stream, then retires it.
module pe_job_scheduler #(
  parameter int FILT_ADDR_LEN = 4,
  parameter int IF_ADDR_LEN   = 4,
  parameter int OUT_W         = 32,
  parameter int CNT_W         = 8,
  parameter int JOB_DEPTH     = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [FILT_ADDR_LEN-1:0] job_filt_len,
  input  logic [IF_ADDR_LEN-1:0]   job_stride_len,
  input  logic [1:0]               job_mod,
  input  logic                     job_acc,
  input  logic [CNT_W-1:0]         job_out_count,
  output logic                     pe_start,
  output logic [FILT_ADDR_LEN-1:0] pe_filt_len,
  output logic [IF_ADDR_LEN-1:0]   pe_stride_len,
  output logic [1:0]               pe_calc_mod,
  output logic                     pe_just_add_flag,
  input  logic                     pe_outbuf_empty,
  output logic                     pe_outbuf_ren,
  input  logic [OUT_W-1:0]         pe_outbuf_dout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_W-1:0]         res_data,
  output logic                     res_last,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              jobs_done
);

  localparam int PTR_W = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]  PTR_ONE = 1;
  localparam logic [WD_W-1:0] WD_ONE  = 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FLUSH} state_e;

  typedef struct packed {
    logic [FILT_ADDR_LEN-1:0] filt_len;
    logic [IF_ADDR_LEN-1:0]   stride_len;
    logic [1:0]               calc_mod;
    logic                     just_add;
    logic [CNT_W-1:0]         out_count;
  } job_t;

  state_e state_q, state_d;

  // Job queue: pointers carry one extra wrap bit to tell full from empty.
  job_t             mem_q [JOB_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             q_empty, q_full, push, pop;
  job_t             head, wr_job;

  logic [FILT_ADDR_LEN-1:0] filt_q, filt_d;
  logic [IF_ADDR_LEN-1:0]   stride_q, stride_d;
  logic [1:0]               mod_q, mod_d;
  logic                     acc_q, acc_d;
  logic [CNT_W-1:0]         remaining_q, remaining_d;
  logic                     rd_pend_q, rd_pend_d;
  logic                     res_valid_q, res_valid_d;
  logic [OUT_W-1:0]         res_data_q, res_data_d;
  logic                     res_last_q, res_last_d;
  logic [WD_W-1:0]          wdog_q, wdog_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [15:0]              jobs_done_q, jobs_done_d;

  logic accept, last_accept, wdog_expire;

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

  // A pop in the same cycle frees the slot, so a full queue can still take a push.
  assign job_ready = !q_full || pop;
  assign push      = job_valid && job_ready;

  always_comb begin
    wr_job            = '0;
    wr_job.filt_len   = job_filt_len;
    wr_job.stride_len = job_stride_len;
    wr_job.calc_mod   = job_mod;
    wr_job.just_add   = job_acc;
    wr_job.out_count  = job_out_count;
  end

  // NOTE: the descriptor array has no reset; the pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_job;
    end
  end

  assign accept      = res_valid_q && res_ready;
  assign last_accept = (state_q == S_RUN) && accept && res_last_q;
  // A completed job wins over a watchdog expiry landing on the same cycle.
  assign wdog_expire = (state_q == S_RUN) && !pe_outbuf_ren && (wdog_q == WD_LAST) &&
                       !last_accept;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!q_empty) state_d = S_LAUNCH;
      S_LAUNCH: state_d = (remaining_q == '0) ? S_FLUSH : S_RUN;
      S_RUN: begin
        if (last_accept)      state_d = S_FLUSH;
        else if (wdog_expire) state_d = S_IDLE;
      end
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    pop           = 1'b0;
    pe_start      = 1'b0;
    pe_outbuf_ren = 1'b0;
    unique case (state_q)
      S_IDLE:   pop = !q_empty;
      S_LAUNCH: pe_start = 1'b1;
      S_RUN:    pe_outbuf_ren = !pe_outbuf_empty && !rd_pend_q &&
                                (!res_valid_q || res_ready) && (remaining_q != '0);
      default:  ;
    endcase
  end

  // Datapath next-state: queue pointers, held config, read pipeline, watchdog.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    filt_d        = filt_q;
    stride_d      = stride_q;
    mod_d         = mod_q;
    acc_d         = acc_q;
    remaining_d   = remaining_q;
    rd_pend_d     = pe_outbuf_ren;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_last_d    = res_last_q;
    wdog_d        = '0;
    timeout_err_d = timeout_err_q || wdog_expire;
    jobs_done_d   = jobs_done_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      filt_d      = head.filt_len;
      stride_d    = head.stride_len;
      mod_d       = head.calc_mod;
      acc_d       = head.just_add;
      remaining_d = head.out_count;
    end

    if (state_q == S_RUN && !pe_outbuf_ren) wdog_d = wdog_q + WD_ONE;

    // Word read last cycle is on pe_outbuf_dout now.
    if (rd_pend_q) begin
      res_data_d  = pe_outbuf_dout;
      res_valid_d = 1'b1;
      res_last_d  = (remaining_q == CNT_ONE);
      remaining_d = remaining_q - CNT_ONE;
    end else if (accept) begin
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
    end

    if (wdog_expire) begin
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
      rd_pend_d   = 1'b0;
      remaining_d = '0;
      wdog_d      = '0;
    end

    if (state_q == S_FLUSH) jobs_done_d = jobs_done_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      filt_q        <= '0;
      stride_q      <= '0;
      mod_q         <= '0;
      acc_q         <= 1'b0;
      remaining_q   <= '0;
      rd_pend_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_last_q    <= 1'b0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      jobs_done_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      filt_q        <= filt_d;
      stride_q      <= stride_d;
      mod_q         <= mod_d;
      acc_q         <= acc_d;
      remaining_q   <= remaining_d;
      rd_pend_q     <= rd_pend_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_last_q    <= res_last_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      jobs_done_q   <= jobs_done_d;
    end
  end

  assign pe_filt_len      = filt_q;
  assign pe_stride_len    = stride_q;
  assign pe_calc_mod      = mod_q;
  assign pe_just_add_flag = acc_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_last         = res_last_q;
  assign timeout_err      = timeout_err_q;
  assign jobs_done        = jobs_done_q;
  assign busy             = (state_q != S_IDLE) || !q_empty;

endmodule
